// File: rtl/multichannel_beamsum_if.sv
// multichannel_beamsum_if: start/length/mask controls, channel RAM read port and summed-output stream of the beam summer.
//   slave  : seen by multichannel_beamsum (takes controls and channel data, drives reads and results)
//   master : seen by the controller / testbench side
interface multichannel_beamsum_if #(
    parameter int NCH = 8,
    parameter int DW  = 32,
    parameter int AW  = 10
);
    localparam int OW = DW + $clog2(NCH);
    logic                  start;
    logic [AW:0]           len;
    logic [NCH-1:0]        ch_mask;
    logic [NCH-1:0]        ch_done;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [NCH*DW-1:0]     ch_data;
    logic signed [OW-1:0]  sum_out;
    logic                  sum_valid;
    logic                  sum_ready;
    logic                  busy;
    logic                  done;
    modport slave (
        input  start, len, ch_mask, ch_done, ch_data, sum_ready,
        output rd_en, rd_addr, sum_out, sum_valid, busy, done
    );
    modport master (
        output start, len, ch_mask, ch_done, ch_data, sum_ready,
        input  rd_en, rd_addr, sum_out, sum_valid, busy, done
    );
endinterface

// File: rtl/multichannel_beamsum.sv
// multichannel_beamsum: reads len words from NCH channel RAMs, sums enabled channels through a pipelined adder tree, streams sums via a FWFT FIFO.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : multichannel_beamsum_if.slave (start/len/ch_mask/ch_done in, rd_en/rd_addr out,
//              ch_data in, sum_out/sum_valid out with sum_ready in, busy/done status out)
module multichannel_beamsum #(
    parameter int NCH        = 8,
    parameter int DW         = 32,
    parameter int AW         = 10,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    multichannel_beamsum_if.slave bus
);
    localparam int CL  = $clog2(NCH);
    localparam int TL  = (CL < 1) ? 1 : CL;
    localparam int OW  = DW + CL;
    localparam int NP  = 1 << TL;
    localparam int PL  = RD_LAT + TL;
    localparam int FAW = $clog2(FIFO_DEPTH);
    // inflight + fifo count can reach 2*FIFO_DEPTH transiently, so two spare bits
    localparam int CW  = FAW + 2;

    typedef enum logic [2:0] {IDLE, WAITCH, ISSUE, DRAIN, FINISH} state_t;

    state_t               state_q;
    logic [AW:0]          len_q;
    logic [NCH-1:0]       mask_q;
    logic                 rd_en_q;
    logic [AW-1:0]        rd_addr_q;
    logic                 done_q;
    logic [CW-1:0]        inflight_q, inflight_d, cnt_q, cnt_d;
    logic [PL-1:0]        vld_q;
    logic [FAW-1:0]       wr_ptr_q, rd_ptr_q;
    logic signed [OW-1:0] mem_q [FIFO_DEPTH];
    logic signed [OW-1:0] tree_q [1:NP-1];
    logic signed [OW-1:0] lv [1:2*NP-1];
    logic [NP*DW-1:0]     data_pad;
    logic [NP-1:0]        mask_pad;
    logic                 push, pop, credit_ok, last_rd, ch_ready;

    assign push       = vld_q[PL-1];
    assign pop        = (cnt_q != '0) && bus.sum_ready;
    assign inflight_d = inflight_q + CW'(rd_en_q) - CW'(push);
    assign cnt_d      = cnt_q + CW'(push) - CW'(pop);
    // Evaluated on next-cycle occupancy because rd_en is registered
    assign credit_ok  = (inflight_d + cnt_d) < CW'(FIFO_DEPTH);
    assign last_rd    = {1'b0, rd_addr_q} == len_q - (AW+1)'(1);
    assign ch_ready   = &(bus.ch_done | ~mask_q);

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.done      = done_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.sum_valid = cnt_q != '0;
    assign bus.sum_out   = (cnt_q == '0) ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            mask_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    len_q   <= bus.len;
                    mask_q  <= bus.ch_mask;
                    state_q <= WAITCH;
                end
                WAITCH: if (len_q == '0) begin
                    state_q <= FINISH;
                    done_q  <= 1'b1;
                end else if (ch_ready) begin
                    state_q <= ISSUE;
                    rd_en_q <= credit_ok;
                end
                ISSUE: if (rd_en_q && last_rd) begin
                    state_q   <= DRAIN;
                    rd_en_q   <= 1'b0;
                    rd_addr_q <= '0;
                end else begin
                    rd_en_q   <= credit_ok;
                    rd_addr_q <= rd_addr_q + AW'(rd_en_q);
                end
                DRAIN: if (inflight_d == '0 && cnt_d == '0) begin
                    state_q <= FINISH;
                    done_q  <= 1'b1;
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Leaves: masked or padding channels become zero, live ones sign-extended to OW
    always_comb begin
        data_pad = (NP*DW)'(bus.ch_data);
        mask_pad = NP'(mask_q);
        for (int i = 1; i < NP; i++) lv[i] = tree_q[i];
        for (int i = 0; i < NP; i++) lv[NP+i] = mask_pad[i] ? OW'(signed'(data_pad[i*DW +: DW])) : '0;
    end

    // Heap-ordered tree: node i sums children 2i, 2i+1; root tree_q[1] is TL registers past the leaves
    always_ff @(posedge clk) begin
        for (int i = 1; i < NP; i++) tree_q[i] <= lv[2*i] + lv[2*i+1];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tree_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            vld_q      <= {vld_q[PL-2:0], rd_en_q};
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_q + FAW'(push);
            rd_ptr_q   <= rd_ptr_q + FAW'(pop);
        end
    end
endmodule

// File: tb/tb_multichannel_beamsum.sv
// tb_multichannel_beamsum: table-driven and randomized checks of multichannel_beamsum against a per-address sum model.
module tb_multichannel_beamsum;
    localparam int NCH   = 8;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multichannel_beamsum_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus();
    multichannel_beamsum #(.NCH(NCH), .DW(DW), .AW(AW), .RD_LAT(1), .FIFO_DEPTH(DEPTH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    multichannel_beamsum_if #(.NCH(5), .DW(16), .AW(4)) bus5();
    multichannel_beamsum #(.NCH(5), .DW(16), .AW(4), .RD_LAT(1), .FIFO_DEPTH(8))
        dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int mode = 0;
    int ready_pct = 100;
    logic signed [DW-1:0] rmem [NCH][64];
    longint got[$];
    longint got5[$];
    int pop_t[$];
    int done_t[$];
    int addr[$];

    typedef struct {
        int             len;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] chd;
        int             mode;
        int             rdy;
        int             n_exp;
        longint         exp [4];
    } vec_t;
    vec_t tbl [8];

    function automatic logic signed [DW-1:0] word(input int k, input int a);
        logic signed [DW-1:0] mn;
        mn = '0;
        mn[DW-1] = 1'b1;
        if (mode == 1) return mn;
        if (mode == 2) return rmem[k][a % 64];
        return DW'(a * 8 + k);
    endfunction

    function automatic longint model_sum(input int a, input logic [NCH-1:0] m);
        longint s = 0;
        for (int k = 0; k < NCH; k++) if (m[k]) s += longint'(word(k, a));
        return s;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Channel RAMs with one cycle read latency; junk when not read
    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) bus.ch_data[k*DW +: DW] <= bus.rd_en ? word(k, int'(bus.rd_addr)) : DW'($urandom);
        for (int k = 0; k < 5; k++) bus5.ch_data[k*16 +: 16] <= bus5.rd_en ? 16'(int'(bus5.rd_addr) * 8 + k) : 16'($urandom);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sum_valid && bus.sum_ready) begin
                got.push_back(longint'(bus.sum_out));
                pop_t.push_back(cyc);
            end
            if (bus.rd_en) addr.push_back(int'(bus.rd_addr));
            if (bus.done) done_t.push_back(cyc);
            if (bus5.sum_valid && bus5.sum_ready) got5.push_back(longint'(bus5.sum_out));
        end
    end

    initial begin
        bus.sum_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.sum_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic run_pass(input int n, input logic [NCH-1:0] m, output int cs);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.len = (AW+1)'(n);
        bus.ch_mask = m;
        cs = cyc;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bd, input int budget);
        int w = 0;
        while (done_t.size() <= bd && w < budget) begin
            @(negedge clk);
            w++;
        end
        check({tag, " done seen"}, longint'(done_t.size() > bd), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic verify(input string tag, input int n, input logic [NCH-1:0] m, input int bg, input int ba, input int bd);
        int bad = 0;
        check({tag, " words"}, got.size() - bg, n);
        for (int i = 0; i < n && bg + i < got.size(); i++)
            check($sformatf("%s word%0d", tag, i), got[bg+i], model_sum(i, m));
        check({tag, " reads"}, addr.size() - ba, n);
        for (int i = ba; i < addr.size(); i++) if (addr[i] != i - ba) bad++;
        check({tag, " addr order"}, bad, 0);
        check({tag, " done pulses"}, done_t.size() - bd, 1);
        if (n > 0 && done_t.size() > bd && pop_t.size() > 0)
            check({tag, " done after last pop"}, done_t[bd], pop_t[pop_t.size()-1] + 1);
        check({tag, " busy idle"}, bus.busy, 0);
    endtask

    initial begin
        int bg, ba, bd, cs, w;
        longint e;
        string tag;
        for (int k = 0; k < NCH; k++) for (int a = 0; a < 64; a++) rmem[k][a] = DW'($urandom);
        tbl[0] = '{4, 8'hFF, 8'hFF, 0, 100, 4, '{28, 92, 156, 220}};
        tbl[1] = '{4, 8'h0F, 8'h0F, 0, 100, 4, '{6, 38, 70, 102}};
        tbl[2] = '{1, 8'hFF, 8'hFF, 1, 100, 1, '{-64'sd17179869184, 0, 0, 0}};
        for (int r = 3; r < 8; r++) begin
            tbl[r].len   = $urandom_range(1, 40);
            tbl[r].mask  = NCH'($urandom);
            tbl[r].chd   = tbl[r].mask | NCH'($urandom);
            tbl[r].mode  = 2;
            tbl[r].rdy   = $urandom_range(30, 100);
            tbl[r].n_exp = 0;
            tbl[r].exp   = '{0, 0, 0, 0};
        end
        bus.start = 1'b0; bus.len = '0; bus.ch_mask = '0; bus.ch_done = '0;
        bus5.start = 1'b0; bus5.len = '0; bus5.ch_mask = '0; bus5.ch_done = '1; bus5.sum_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset sum_valid", bus.sum_valid, 0);
        check("reset sum_out", bus.sum_out, 0);
        check("reset rd_en", bus.rd_en, 0);
        check("reset rd_addr", bus.rd_addr, 0);
        check("reset done", bus.done, 0);
        #1 rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            tag = $sformatf("row%0d", r);
            mode = tbl[r].mode; ready_pct = tbl[r].rdy; bus.ch_done = tbl[r].chd;
            bg = got.size(); ba = addr.size(); bd = done_t.size();
            run_pass(tbl[r].len, tbl[r].mask, cs);
            wait_done(tag, bd, 3000);
            verify(tag, tbl[r].len, tbl[r].mask, bg, ba, bd);
            for (int j = 0; j < tbl[r].n_exp; j++)
                check($sformatf("%s table%0d", tag, j), (bg + j < got.size()) ? got[bg+j] : 64'sd0, tbl[r].exp[j]);
        end

        mode = 0; ready_pct = 100; bus.ch_done = 8'h7F;
        bg = got.size(); ba = addr.size(); bd = done_t.size();
        run_pass(2, 8'hFF, cs);
        repeat (10) @(negedge clk);
        check("waitch reads blocked", addr.size() - ba, 0);
        check("waitch busy", bus.busy, 1);
        bus.ch_done = 8'hFF;
        wait_done("waitch", bd, 200);
        verify("waitch", 2, 8'hFF, bg, ba, bd);

        ready_pct = 0;
        bg = got.size(); ba = addr.size(); bd = done_t.size();
        run_pass(20, 8'hFF, cs);
        while (cyc < cs + 30) @(negedge clk);
        check("stall reads", addr.size() - ba, DEPTH);
        check("stall words", got.size() - bg, 0);
        check("stall sum_valid", bus.sum_valid, 1);
        ready_pct = 100;
        wait_done("stall", bd, 500);
        verify("stall", 20, 8'hFF, bg, ba, bd);

        ba = addr.size();
        run_pass(10, 8'hFF, cs);
        w = 0;
        while (addr.size() - ba < 3 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("abort third read", addr.size() - ba, 3);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort busy", bus.busy, 0);
        check("abort sum_valid", bus.sum_valid, 0);
        check("abort sum_out", bus.sum_out, 0);
        #1 rst = 1'b0;
        bg = got.size(); bd = done_t.size();
        repeat (12) @(negedge clk);
        check("abort stale words", got.size() - bg, 0);
        check("abort no done", done_t.size() - bd, 0);
        bg = got.size(); ba = addr.size(); bd = done_t.size();
        run_pass(2, 8'hFF, cs);
        wait_done("post_abort", bd, 200);
        verify("post_abort", 2, 8'hFF, bg, ba, bd);

        ba = addr.size(); bd = done_t.size();
        run_pass(0, 8'hFF, cs);
        repeat (6) @(negedge clk);
        check("len0 reads", addr.size() - ba, 0);
        check("len0 done pulses", done_t.size() - bd, 1);
        if (done_t.size() > bd) check("len0 done within 3", longint'(done_t[bd] - cs <= 3), 1);

        bg = got.size(); ba = addr.size(); bd = done_t.size();
        run_pass(1, 8'hFF, cs);
        w = 0;
        while (!bus.done && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("overlap first done", bus.done, 1);
        bus.start = 1'b1; bus.len = (AW+1)'(5);
        @(negedge clk);
        bus.len = (AW+1)'(3);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("overlap", bd + 1, 200);
        check("overlap words", got.size() - bg, 4);
        check("overlap reads", addr.size() - ba, 4);
        if (got.size() - bg == 4) begin
            check("overlap word1", got[bg+1], model_sum(0, 8'hFF));
            check("overlap word3", got[bg+3], model_sum(2, 8'hFF));
        end

        bus5.len = 5'd4; bus5.ch_mask = 5'h1F;
        @(posedge clk);
        #1 bus5.start = 1'b1;
        @(posedge clk);
        #1 bus5.start = 1'b0;
        w = 0;
        while (!bus5.done && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("nch5 done seen", bus5.done, 1);
        repeat (3) @(negedge clk);
        check("nch5 words", got5.size(), 4);
        for (int a = 0; a < 4 && a < got5.size(); a++) begin
            e = 0;
            for (int k = 0; k < 5; k++) e += a * 8 + k;
            check($sformatf("nch5 word%0d", a), got5[a], e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multichannel_beamsum.md
MULTICHANNEL_BEAMSUM -- requirements
Module: multichannel_beamsum

Interface
REQ-001 Parameter NCH, default 8: number of beamformer channels summed.
REQ-002 Parameter DW, default 32: signed width of each channel output word.
REQ-003 Parameter AW, default 10: width of the shared channel-output read address.
REQ-004 Parameter RD_LAT, default 1: cycles from rd_en to valid ch_data (channel BRAM latency).
REQ-005 Parameter FIFO_DEPTH, default 8 (power of 2, >= RD_LAT+TL+1): output FIFO depth.
REQ-006 Derived: TL = max(1, ceil(log2(NCH))) adder-tree stages; OW = DW + ceil(log2(NCH)).
REQ-007 clk  in  1  single clock for all logic.
REQ-008 rst  in  1  synchronous reset, active-high.
REQ-009 start  in  1  one-cycle pulse starting a summing pass.
REQ-010 len  in  AW+1  number of samples to sum, sampled on accepted start.
REQ-011 ch_mask  in  NCH  per-channel enable (1 = include), sampled on accepted start.
REQ-012 ch_done  in  NCH  per-channel beamforming-complete flags.
REQ-013 rd_en  out  1  read strobe to all channel output RAMs.
REQ-014 rd_addr  out  AW  shared read address.
REQ-015 ch_data  in  NCH*DW  channel words, channel k at bits [k*DW +: DW].
REQ-016 sum_out  out  OW  signed sum, valid while sum_valid high.
REQ-017 sum_valid  out  1  FIFO non-empty.
REQ-018 sum_ready  in  1  consumer accepts sum_out when sum_valid && sum_ready.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 done  out  1  one-cycle pulse at pass completion.

Function
REQ-021 States: IDLE, WAITCH, ISSUE, DRAIN, FINISH.
REQ-022 IDLE: start accepted -> latch len, ch_mask; go WAITCH; start ignored in all other states.
REQ-023 WAITCH: when (ch_done | ~mask_q) is all-ones -> ISSUE; if len_q == 0 -> FINISH directly.
REQ-024 ISSUE: rd_en = 1 only when inflight + fifo_count < FIFO_DEPTH (credit rule); rd_addr starts at 0, increments by 1 per issued read.
REQ-025 After issuing read len_q-1 -> DRAIN; rd_en and rd_addr hold 0 outside ISSUE.
REQ-026 Data pipeline: valid tag delayed RD_LAT cycles, then TL registered adder-tree stages, then FIFO write; rd_en to sum_valid latency RD_LAT+TL+1 with empty FIFO.
REQ-027 Each channel word sign-extended to OW; masked channels contribute 0; no saturation, full-precision sum.
REQ-028 Tree for non-power-of-2 NCH pads with zero leaves.
REQ-029 FIFO first-word-fall-through; sum_out = head entry; simultaneous push and pop at full or empty allowed, count unchanged.
REQ-030 Credit rule guarantees FIFO never overflows; pipeline never stalls; sum_ready low indefinitely only blocks further reads.
REQ-031 DRAIN: when inflight == 0 and FIFO empty after final pop -> FINISH.
REQ-032 FINISH: done = 1 for exactly one cycle, then IDLE; busy low from IDLE.
REQ-033 Output order equals address order 0..len_q-1; exactly len_q words emitted per pass.
REQ-034 Address wrap: len up to 2^AW; rd_addr never exceeds len_q-1.
REQ-035 start in same cycle as done ignored; start on next cycle accepted.

Reset
REQ-036 rst high at clock edge: state IDLE, rd_en 0, rd_addr 0, FIFO emptied, inflight 0, pipeline valids cleared, busy 0, done 0, sum_valid 0.
REQ-037 sum_out is 0 after reset; reset mid-pass aborts without done pulse, and no stale word appears afterward.
REQ-038 Latched len_q, mask_q cleared to 0 by reset.

Verification
REQ-039 NCH=8, all mask 1, ch_done all 1, channel k at addr a = a*8+k, len=4, sum_ready=1 -> sum_out 28,92,156,220, done one cycle after last pop.
REQ-040 Same data, ch_mask=8'h0F -> sums 6,38,70,102; ch_done[7:4]=0 does not block start of reads.
REQ-041 All channels = -2^31 (DW=32), len=1 -> sum_out = -2^34 on OW=35 bits, no overflow.
REQ-042 len=20, sum_ready low for 30 cycles after start -> exactly FIFO_DEPTH reads issued, no lost/duplicate words; release -> all 20 in order.
REQ-043 rst asserted at the 3rd issued read of len=10 -> next cycle busy=0, sum_valid=0; a new pass with len=2 outputs exactly 2 correct words.
REQ-044 len=0 -> no rd_en, done pulses within 3 cycles of start; NCH=5 build passes REQ-039 style check with sums of 5 channels.
